pitch_period_estimator: RTL and testbench
=========================================

// Module: pitch_period_estimator
// PURPOSE
//  Downstream consumer of the audio capture buffer: after capture completes, scans the N_SAMPLES
//  signed PCM samples in buffer RAM and detects rising zero crossings. Computes the mean fundamental
//  period in samples (fixed point) for the note-matching / display stage. Runs in the ~1.024 MHz mic clock domain.
// PARAMETERS
//  N_SAMPLES  2048  samples scanned per run (addresses 0..N_SAMPLES-1)
//  ADDR_W     11    buffer address width; N_SAMPLES <= 2**ADDR_W
//  DATA_W     10    signed sample width
//  FRAC_W     4     fractional bits of period output
//  PERIOD_W   15    ADDR_W+FRAC_W; period output width, also divider iteration count
//  HYST       8     hysteresis threshold magnitude (used only with PPE_HYSTERESIS_EN)
// PORTS
//  clk        in   1         block clock (mic clock domain)
//  rst        in   1         asynchronous, active-high reset
//  start      in   1         1-cycle request to estimate (asserted when capture reports done)
//  mem_addr   out  ADDR_W    buffer read address
//  mem_data   in   DATA_W    signed sample; synchronous RAM, valid 1 cycle after mem_addr
//  busy       out  1         high from accepted start until done
//  done       out  1         1-cycle pulse, result registers updated
//  valid      out  1         last result meaningful (>=2 crossings found)
//  period     out  PERIOD_W  mean period in samples, unsigned Q(ADDR_W).(FRAC_W)
//  xings      out  ADDR_W    rising crossings counted in last run
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; mem_addr=0, busy=0, done=0, valid=0, period=0, xings=0.
//  - FSM IDLE -> SCAN -> (DIVIDE) -> DONE -> IDLE.
//  - IDLE: start=1 accepted; busy=1 next cycle; counters/first/last cleared, detector disarmed.
//    start outside IDLE ignored (no restart, no queueing).
//  - SCAN: mem_addr issues 0..N_SAMPLES-1 on consecutive cycles; sample i evaluated the cycle after
//    address i; state spans N_SAMPLES+1 cycles. mem_addr holds N_SAMPLES-1 afterwards, returns to 0 in IDLE.
//  - Crossing at sample i: record first=i on first crossing, last=i on every crossing, xings+=1
//    (saturates at 2**ADDR_W-1). Sample 0 is never a crossing.
//  - After SCAN: xings<2 -> DONE directly, valid=0, period=0.
//    Else DIVIDE: restoring divider, one quotient bit per cycle, PERIOD_W cycles,
//    numerator=(last-first)<<FRAC_W, denominator=xings-1; quotient truncated (floor); valid=1.
//  - DONE: period/valid/xings registered, done=1 for exactly one cycle, busy=0 next cycle, back to IDLE.
//  - Latency start->done: N_SAMPLES+2 cycles (invalid) or N_SAMPLES+PERIOD_W+2 cycles (valid).
//  - Outputs period/valid/xings hold between runs; change only at DONE or reset.
//  - All sample comparisons signed; no overflow possible (last-first < 2**ADDR_W).
// CONFIGURATION
//  PPE_HYSTERESIS_EN defined: detector arms when sample <= -HYST; crossing when armed and
//    sample >= +HYST, then disarms. Starts disarmed each run.
//  Not defined: plain sign detector, crossing when prev<0 and cur>=0; prev initialised to 0 each run.
//    HYST unused.
// TESTING
//  1 Square +/-100, period 64, starting +100 -> xings=31, valid=1, period=1024 (64.0), done at start+N+PERIOD_W+2.
//  2 Square +/-100, period 100, starting +100 -> xings=20, period=1600 (100.0).
//  3 All -100, +100 only at idx 10,43,77 -> xings=3, period=536 (33.5).
//  4 All-zero buffer -> xings=0, valid=0, period=0, done at start+N+2.
//  5 Noise alternating +5/-5 -> with EN (HYST=8): xings=0, valid=0; without EN: xings=1023, period=32 (2.0).
//  6 start repeated mid-SCAN ignored (single done); rst pulse mid-DIVIDE -> all outputs 0 immediately,
//    next start runs normally with case-1 result.

Source files
------------

// File: rtl/pitch_period_estimator.sv
// rtl/pitch_period_estimator.sv - mean rising-zero-crossing period of a captured PCM buffer (option: PPE_HYSTERESIS_EN)
module pitch_period_estimator #(
   parameter int N_SAMPLES = 2048,
   parameter int ADDR_W    = 11,
   parameter int DATA_W    = 10,
   parameter int FRAC_W    = 4,
   parameter int PERIOD_W  = 15,
   parameter int HYST      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_data,
   output logic                busy,
   output logic                done,
   output logic                valid,
   output logic [PERIOD_W-1:0] period,
   output logic [ADDR_W-1:0]   xings
);

   localparam int CNT_W  = ADDR_W + 1;
   localparam int DCNT_W = $clog2(PERIOD_W + 1);
   localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(N_SAMPLES);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_SAMPLES - 1);
   localparam logic [ADDR_W-1:0] XING_MAX  = '1;
   localparam logic [DCNT_W-1:0] DIV_LAST  = DCNT_W'(PERIOD_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DIVIDE, S_DONE} state_t;

   state_t state, state_nxt;

   // Scan bookkeeping: scan_cnt runs one ahead of the sample being evaluated
   logic [CNT_W-1:0]  scan_cnt;
   logic [ADDR_W-1:0] xing_cnt, first_idx, last_idx;
   logic              det_arm;

   // Restoring divider registers
   logic [PERIOD_W-1:0] quo;
   logic [ADDR_W-1:0]   rem, den;
   logic [DCNT_W-1:0]   div_cnt;

   logic signed [DATA_W-1:0] sample;
   logic [ADDR_W-1:0]   smp_idx;
   logic                sample_ok, xing, arm_nxt;
   logic [ADDR_W-1:0]   cnt_nxt, first_nxt, last_nxt;
   logic [ADDR_W:0]     rem_sh;
   logic [ADDR_W-1:0]   rem_nxt;
   logic [PERIOD_W-1:0] quo_nxt, num_init;

   assign sample    = mem_data;
   assign smp_idx   = ADDR_W'(scan_cnt - 1'b1);
   assign sample_ok = (state == S_SCAN) && (scan_cnt != '0);

`ifdef PPE_HYSTERESIS_EN
   localparam logic signed [DATA_W-1:0] HYST_P = DATA_W'(HYST);
   localparam logic signed [DATA_W-1:0] HYST_N = -HYST_P;

   // Hysteresis detector: arm below -HYST, fire (and disarm) above +HYST
   always_comb begin
      xing    = 1'b0;
      arm_nxt = det_arm;
      if (det_arm && (sample >= HYST_P)) begin
         xing    = 1'b1;
         arm_nxt = 1'b0;
      end else if (sample <= HYST_N) begin
         arm_nxt = 1'b1;
      end
   end
`else
   // Sign detector: det_arm remembers that the previous sample was negative
   always_comb begin
      xing    = det_arm && !sample[DATA_W-1];
      arm_nxt = sample[DATA_W-1];
   end
`endif

   // Crossing bookkeeping for the sample arriving this cycle
   always_comb begin
      cnt_nxt   = xing_cnt;
      first_nxt = first_idx;
      last_nxt  = last_idx;
      if (sample_ok && xing) begin
         if (xing_cnt == '0) first_nxt = smp_idx;
         last_nxt = smp_idx;
         if (xing_cnt != XING_MAX) cnt_nxt = xing_cnt + 1'b1;
      end
   end

   // One restoring-division step plus the numerator loaded when scanning ends
   always_comb begin
      rem_sh   = {rem, quo[PERIOD_W-1]};
      quo_nxt  = {quo[PERIOD_W-2:0], 1'b0};
      rem_nxt  = rem_sh[ADDR_W-1:0];
      if (rem_sh >= {1'b0, den}) begin
         rem_nxt = ADDR_W'(rem_sh - {1'b0, den});
         quo_nxt = {quo[PERIOD_W-2:0], 1'b1};
      end
      num_init = PERIOD_W'({ADDR_W'(last_nxt - first_nxt), {FRAC_W{1'b0}}});
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_SCAN;
         S_SCAN:   if (scan_cnt == SCAN_LAST)
                      state_nxt = (cnt_nxt >= ADDR_W'(2)) ? S_DIVIDE : S_DONE;
         S_DIVIDE: if (div_cnt == DIV_LAST) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Datapath, address generation and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         valid     <= 1'b0;
         period    <= '0;
         xings     <= '0;
         scan_cnt  <= '0;
         xing_cnt  <= '0;
         first_idx <= '0;
         last_idx  <= '0;
         det_arm   <= 1'b0;
         quo       <= '0;
         rem       <= '0;
         den       <= '0;
         div_cnt   <= '0;
      end else begin
         busy <= (state_nxt != S_IDLE);
         done <= (state_nxt == S_DONE);
         case (state)
            S_IDLE: begin
               mem_addr <= '0;
               if (start) begin
                  scan_cnt  <= '0;
                  xing_cnt  <= '0;
                  first_idx <= '0;
                  last_idx  <= '0;
                  det_arm   <= 1'b0;
               end
            end
            S_SCAN: begin
               scan_cnt  <= scan_cnt + 1'b1;
               if (mem_addr != ADDR_LAST) mem_addr <= mem_addr + 1'b1;
               if (sample_ok) det_arm <= arm_nxt;
               xing_cnt  <= cnt_nxt;
               first_idx <= first_nxt;
               last_idx  <= last_nxt;
               if (scan_cnt == SCAN_LAST) begin
                  if (cnt_nxt >= ADDR_W'(2)) begin
                     quo     <= num_init;
                     rem     <= '0;
                     den     <= cnt_nxt - 1'b1;
                     div_cnt <= '0;
                  end else begin
                     valid  <= 1'b0;
                     period <= '0;
                     xings  <= cnt_nxt;
                  end
               end
            end
            S_DIVIDE: begin
               quo     <= quo_nxt;
               rem     <= rem_nxt;
               div_cnt <= div_cnt + 1'b1;
               if (div_cnt == DIV_LAST) begin
                  period <= quo_nxt;
                  valid  <= 1'b1;
                  xings  <= xing_cnt;
               end
            end
            S_DONE: mem_addr <= '0;
            default: mem_addr <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_pitch_period_estimator.sv
// tb/tb_pitch_period_estimator.sv - randomized and directed bench for pitch_period_estimator
module tb_pitch_period_estimator;
   localparam int N    = 2048;
   localparam int AW   = 11;
   localparam int DW   = 10;
   localparam int FW   = 4;
   localparam int PW   = 15;
   localparam int HYST = 8;
   localparam int LIMIT = N + PW + 50;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          busy, done, valid;
   logic [PW-1:0] period;
   logic [AW-1:0] xings;

   logic signed [DW-1:0] mem [N];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always @(posedge clk) mem_data <= mem[mem_addr];

   pitch_period_estimator #(
      .N_SAMPLES(N), .ADDR_W(AW), .DATA_W(DW), .FRAC_W(FW), .PERIOD_W(PW), .HYST(HYST)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_data(mem_data),
      .busy(busy), .done(done), .valid(valid), .period(period), .xings(xings)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: walk the buffer applying the crossing rule, then mean period by integer division
   task automatic model(output int ex, output int ep, output bit ev);
      int prev, cur, first, last;
      bit armed, x;
      prev = 0; armed = 0; first = 0; last = 0; ex = 0;
      for (int i = 0; i < N; i++) begin
         cur = mem[i];
`ifdef PPE_HYSTERESIS_EN
         x = 0;
         if (armed && cur >= HYST) begin x = 1; armed = 0; end
         else if (cur <= -HYST) armed = 1;
`else
         x = (prev < 0) && (cur >= 0);
         prev = cur;
`endif
         if (x) begin
            if (ex == 0) first = i;
            last = i;
            if (ex < (1 << AW) - 1) ex++;
         end
      end
      ev = (ex >= 2);
      ep = ev ? ((last - first) * (1 << FW)) / (ex - 1) : 0;
   endtask

   task automatic fill_square(input int per, input int amp, input int phase);
      for (int i = 0; i < N; i++)
         mem[i] = (((i + phase) % per) < per / 2) ? DW'(amp) : DW'(-amp);
   endtask

   task automatic fill_const(input int v);
      for (int i = 0; i < N; i++) mem[i] = DW'(v);
   endtask

   task automatic run_check(input string tag, input bit inject);
      int ex, ep, lat, exp_lat;
      bit ev;
      model(ex, ep, ev);
      exp_lat = ev ? N + PW + 2 : N + 2;
      @(negedge clk); start = 1'b1;
      @(posedge clk); lat = 1;
      @(negedge clk); start = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      while (!done && lat < LIMIT) begin
         if (lat == 500) chk({tag, "_addr_mid"}, mem_addr, 499);
         start = inject && (lat == 300);
         @(posedge clk); lat++;
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_xings"}, xings, ex);
      chk({tag, "_valid"}, valid, ev);
      chk({tag, "_period"}, period, ep);
      chk({tag, "_addr_end"}, mem_addr, N - 1);
      @(posedge clk); @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_addr_idle"}, mem_addr, 0);
      if (inject) begin
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy || done) chk({tag, "_no_restart"}, {busy, done}, 0);
         end
         chk({tag, "_still_idle"}, busy, 0);
      end
   endtask

   initial begin
      int r;
      rst = 1'b1; start = 1'b0;
      fill_const(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", valid, 0);
      chk("rst_period", period, 0);
      chk("rst_xings", xings, 0);
      chk("rst_addr", mem_addr, 0);
      rst = 1'b0;

      fill_square(64, 100, 0);
      run_check("sq64", 0);
      chk("sq64_abs", period, 1024);
      fill_square(100, 100, 0);
      run_check("sq100", 0);
      chk("sq100_abs", period, 1600);
      fill_const(-100);
      mem[10] = 100; mem[43] = 100; mem[77] = 100;
      run_check("spikes", 0);
      chk("spikes_abs", period, 536);
      fill_const(0);
      run_check("zero", 0);
      for (int i = 0; i < N; i++) mem[i] = (i % 2 == 0) ? DW'(5) : DW'(-5);
      run_check("alt5", 0);
`ifdef PPE_HYSTERESIS_EN
      chk("alt5_abs", xings, 0);
`else
      chk("alt5_abs", period, 32);
`endif

      fill_square(64, 100, 0);
      run_check("inject", 1);

      // reset in the middle of the divide phase
      @(negedge clk); start = 1'b1;
      @(posedge clk); @(negedge clk); start = 1'b0;
      repeat (N + 4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_period", period, 0);
      chk("mid_rst_xings", xings, 0);
      chk("mid_rst_addr", mem_addr, 0);
      @(negedge clk); rst = 1'b0;
      run_check("after_rst", 0);
      chk("after_rst_abs", period, 1024);

      for (int t = 0; t < 8; t++) begin
         r = t % 4;
         case (r)
            0: fill_square($urandom_range(2, 400), $urandom_range(1, 511), $urandom_range(0, 399));
            1: begin
               fill_const(-$urandom_range(1, 300));
               for (int k = 0; k < $urandom_range(0, 12); k++) mem[$urandom_range(1, N - 1)] = DW'($urandom_range(0, 300));
            end
            2: for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(0, 1023));
            default: for (int i = 0; i < N; i++) mem[i] = DW'(int'($urandom_range(0, 40)) - 20);
         endcase
         run_check($sformatf("rand%0d", t), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
